puf_scan_ctrl: RTL and testbench

- Parametrised challenge/response sequencer for a bank of NUM_PUF single-bit PUF cells; generalises the fixed 2-bit-select, fixed-length PUF wrapper.
- Challenge is scanned in serially on si and expanded per response bit by an LFSR.
- Each selected PUF is evaluated once per bit with a programmable settle time. The response is shifted out serially on so.
- Sits between the user-area scan/GPIO interface and the PUF macro array.

---
 rtl/puf_pkg.sv | 18 +
 rtl/puf_lfsr.sv | 50 +++++
 rtl/puf_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_puf_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge/response sequencer: FSM encoding,
// default LFSR feedback mask and the length-code decoder.
package puf_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EVAL   = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_UNLOAD = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS_DEF = 32'h8020_0003;

  function automatic int unsigned resp_len(input logic [1:0] code, input int unsigned resp_max);
    return (32'(code) + 32'd1) * (resp_max / 32'd4);
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge register: serial scan-in, Galois LFSR step and a zero guard that
// forces a locked-up all-zero state to 1.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int              W    = 32,
  parameter logic [W-1:0]    TAPS = W'(LFSR_TAPS_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         shift_in,
  input  logic         guard,
  input  logic         step,
  output logic [W-1:0] q
);

  logic [W-1:0] chal_d;
  logic [W-1:0] chal_q;

  // next challenge: guard, then LFSR step, then scan shift
  always_comb begin
    chal_d = chal_q;
    if (guard) begin
      if (chal_q == '0) begin
        chal_d = W'(1'b1);
      end else begin
        chal_d = chal_q;
      end
    end else if (step) begin
      chal_d = (chal_q >> 1) ^ (chal_q[0] ? TAPS : '0);
    end else if (shift_en) begin
      chal_d = {chal_q[W-2:0], shift_in};
    end else begin
      chal_d = chal_q;
    end
  end

  // challenge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chal_q <= '0;
    end else begin
      chal_q <= chal_d;
    end
  end

  assign q = chal_q;

endmodule

// File: rtl/puf_scan_ctrl.sv
// Challenge/response sequencer for a bank of single-bit PUF cells.
// Build option: define PUF_MAJORITY_VOTE_EN to store the majority of 3 evaluations per bit.
module puf_scan_ctrl
  import puf_pkg::*;
#(
  parameter int                 NUM_PUF    = 4,
  parameter int                 CHAL_W     = 32,
  parameter int                 RESP_MAX   = 32,
  parameter int                 SETTLE_CYC = 8,
  parameter logic [CHAL_W-1:0]  LFSR_TAPS  = CHAL_W'(LFSR_TAPS_DEF),
  localparam int                SEL_W      = (NUM_PUF > 1) ? $clog2(NUM_PUF) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               si,
  input  logic               scan_en,
  input  logic               start,
  input  logic [SEL_W-1:0]   puf_sel,
  input  logic [1:0]         length,
  input  logic [NUM_PUF-1:0] puf_resp,
  output logic [NUM_PUF-1:0] puf_en,
  output logic [CHAL_W-1:0]  puf_chal,
  output logic               so,
  output logic               busy,
  output logic               done,
  output logic               sel_err
);

  localparam int CNT_W = $clog2(RESP_MAX + 1);
  localparam int IDX_W = $clog2(RESP_MAX);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [2:0]          state_d,   state_q;
  logic [SEL_W-1:0]    sel_d,     sel_q;
  logic [CNT_W-1:0]    n_d,       n_q;
  logic [CNT_W-1:0]    bit_cnt_d, bit_cnt_q;
  logic [SET_W-1:0]    set_cnt_d, set_cnt_q;
  logic [RESP_MAX-1:0] resp_d,    resp_q;
  logic [NUM_PUF-1:0]  puf_en_d,  puf_en_q;
  logic                so_d,      so_q;
  logic                busy_d,    busy_q;
  logic                done_d,    done_q;
  logic                sel_err_d, sel_err_q;

  logic             sel_ok;
  logic             last_bit;
  logic             bit_done;
  logic             bit_val;
  logic             lfsr_shift;
  logic             lfsr_guard;
  logic             lfsr_step;
  logic [IDX_W-1:0] unload_idx;

  assign sel_ok   = ({{(32-SEL_W){1'b0}}, puf_sel} < 32'(NUM_PUF));
  assign last_bit = (bit_cnt_q == (n_q - CNT_W'(1'b1)));

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] vote_cnt_d, vote_cnt_q;
  logic [1:0] ones_d,     ones_q;

  // three samples per bit with the same challenge; the stored bit is their majority
  always_comb begin
    bit_done = (vote_cnt_q == 2'd2);
    bit_val  = (ones_q == 2'd2) || ((ones_q == 2'd1) && puf_resp[sel_q]);
    if (state_q == ST_SAMPLE) begin
      if (bit_done) begin
        vote_cnt_d = 2'd0;
        ones_d     = 2'd0;
      end else begin
        vote_cnt_d = vote_cnt_q + 2'd1;
        ones_d     = ones_q + {1'b0, puf_resp[sel_q]};
      end
    end else begin
      vote_cnt_d = vote_cnt_q;
      ones_d     = ones_q;
    end
  end

  // vote bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_cnt_q <= 2'd0;
      ones_q     <= 2'd0;
    end else begin
      vote_cnt_q <= vote_cnt_d;
      ones_q     <= ones_d;
    end
  end
`else
  assign bit_done = 1'b1;
  assign bit_val  = puf_resp[sel_q];
`endif

  // sequencer next-state and datapath
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    n_d        = n_q;
    bit_cnt_d  = bit_cnt_q;
    set_cnt_d  = set_cnt_q;
    resp_d     = resp_q;
    sel_err_d  = sel_err_q;
    lfsr_shift = 1'b0;
    lfsr_guard = 1'b0;
    lfsr_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_guard = 1'b1;
          sel_d      = puf_sel;
          n_d        = CNT_W'(resp_len(length, 32'(RESP_MAX)));
          bit_cnt_d  = '0;
          set_cnt_d  = '0;
          resp_d     = '0;
          sel_err_d  = !sel_ok;
          // an out-of-range select never drives the bank; it unloads zeros instead
          if (sel_ok) begin
            state_d = ST_EVAL;
          end else begin
            state_d = ST_UNLOAD;
          end
        end else begin
          lfsr_shift = scan_en;
        end
      end
      ST_EVAL: begin
        if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
          set_cnt_d = '0;
          state_d   = ST_SAMPLE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1'b1);
        end
      end
      ST_SAMPLE: begin
        if (bit_done) begin
          resp_d    = {resp_q[RESP_MAX-2:0], bit_val};
          lfsr_step = 1'b1;
          if (last_bit) begin
            bit_cnt_d = '0;
            state_d   = ST_UNLOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
            state_d   = ST_EVAL;
          end
        end else begin
          state_d = ST_EVAL;
        end
      end
      ST_UNLOAD: begin
        resp_d = {resp_q[RESP_MAX-2:0], 1'b0};
        if (last_bit) begin
          bit_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // registered outputs decoded from the next state; the oldest bit sits at n-1
  always_comb begin
    unload_idx = IDX_W'(n_d - CNT_W'(1'b1));
    puf_en_d   = (state_d == ST_EVAL) ? (NUM_PUF'(1'b1) << sel_d) : '0;
    so_d       = (state_d == ST_UNLOAD) ? resp_d[unload_idx] : 1'b0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // sequencer state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      n_q       <= '0;
      bit_cnt_q <= '0;
      set_cnt_q <= '0;
      resp_q    <= '0;
      puf_en_q  <= '0;
      so_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      n_q       <= n_d;
      bit_cnt_q <= bit_cnt_d;
      set_cnt_q <= set_cnt_d;
      resp_q    <= resp_d;
      puf_en_q  <= puf_en_d;
      so_q      <= so_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
    end
  end

  puf_lfsr #(
    .W    (CHAL_W),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst      (reset),
    .shift_en (lfsr_shift),
    .shift_in (si),
    .guard    (lfsr_guard),
    .step     (lfsr_step),
    .q        (puf_chal)
  );

  assign puf_en  = puf_en_q;
  assign so      = so_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_puf_scan_ctrl.sv
// Scoreboard bench for puf_scan_ctrl (NUM_PUF=3, SETTLE_CYC=4): expected challenges and
// response bits are queued at start and compared as the DUT evaluates and unloads.
module tb_puf_scan_ctrl;

  localparam int          NP   = 3;
  localparam int          CW   = 32;
  localparam int          SC   = 4;
  localparam logic [31:0] TAPS = 32'h8020_0003;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VOTES = 3;
`else
  localparam int VOTES = 1;
`endif

  logic          clk;
  logic          reset;
  logic          si;
  logic          scan_en;
  logic          start;
  logic [1:0]    puf_sel;
  logic [1:0]    length;
  logic [NP-1:0] puf_resp;
  logic [NP-1:0] puf_en;
  logic [CW-1:0] puf_chal;
  logic          so;
  logic          busy;
  logic          done;
  logic          sel_err;

  int            n_tests = 0;
  int            n_fail  = 0;
  bit            resp_mode;
  logic [NP-1:0] resp_const;
  logic [CW-1:0] chal_model;
  logic          exp_so_q[$];
  logic [CW-1:0] exp_chal_q[$];

  puf_scan_ctrl #(
    .NUM_PUF    (NP),
    .CHAL_W     (CW),
    .RESP_MAX   (32),
    .SETTLE_CYC (SC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .si       (si),
    .scan_en  (scan_en),
    .start    (start),
    .puf_sel  (puf_sel),
    .length   (length),
    .puf_resp (puf_resp),
    .puf_en   (puf_en),
    .puf_chal (puf_chal),
    .so       (so),
    .busy     (busy),
    .done     (done),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PUF bank stand-in: either fixed bits or the parity of the applied challenge
  always_comb puf_resp = resp_mode ? {NP{^puf_chal}} : resp_const;

  function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 32'h0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    start   = 1'b0;
    scan_en = 1'b0;
    si      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    chal_model = '0;
    @(negedge clk);
  endtask

  task automatic scan_in(input logic [CW-1:0] val);
    for (int i = CW - 1; i >= 0; i--) begin
      @(negedge clk);
      si      = val[i];
      scan_en = 1'b1;
    end
    @(negedge clk);
    scan_en    = 1'b0;
    si         = 1'b0;
    chal_model = val;
    chk("scan_in", puf_chal, val);
  endtask

  task automatic run_op(input logic [1:0] sel, input logic [1:0] len, input bit with_scan,
                        input bit repulse);
    int            n, busy_cyc, done_cnt, done_at, en_cyc, en_rise, bad_en, so_stray, cyc, idx;
    bit            valid;
    logic [CW-1:0] c0, cm;
    logic [NP-1:0] oh, prev_en;
    logic          so_hist[$];
    n     = (int'(len) + 1) * 8;
    valid = (int'(sel) < NP);
    oh    = valid ? (NP'(1'b1) << sel) : '0;
    c0    = (chal_model == '0) ? 32'h1 : chal_model;
    cm    = c0;
    for (int k = 0; k < n; k++) begin
      exp_so_q.push_back(valid ? (resp_mode ? ^cm : resp_const[sel]) : 1'b0);
      if (valid) begin
        for (int v = 0; v < VOTES; v++) exp_chal_q.push_back(cm);
        cm = lfsr_next(cm);
      end
    end
    @(negedge clk);
    puf_sel = sel;
    length  = len;
    scan_en = with_scan;
    si      = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    scan_en = 1'b0;
    chk("chal_at_start", puf_chal, c0);
    busy_cyc = 0; done_cnt = 0; done_at = -1; en_cyc = 0; en_rise = 0;
    bad_en = 0; so_stray = 0; cyc = 0; prev_en = '0;
    while (busy === 1'b1 && cyc < 2000) begin
      busy_cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = busy_cyc;
      end
      if (puf_en !== '0) begin
        en_cyc++;
        if (puf_en !== oh) bad_en++;
        if (prev_en === '0 && exp_chal_q.size() > 0) chk("chal", puf_chal, exp_chal_q.pop_front());
        if (prev_en === '0) en_rise++;
      end
      prev_en = puf_en;
      so_hist.push_back(so);
      if (repulse && cyc == 10) begin
        start = 1'b1; scan_en = 1'b1; puf_sel = 2'd0; length = 2'd3;
      end else begin
        start = 1'b0; scan_en = 1'b0; puf_sel = sel; length = len;
      end
      cyc++;
      @(negedge clk);
    end
    chk("timeout", busy, 1'b0);
    chk("done_cnt", done_cnt, 1);
    chk("done_last", done_at, busy_cyc);
    if (valid) begin
      chk("busy_cycles", busy_cyc, n * VOTES * (SC + 1) + n + 1);
      chk("en_rise", en_rise, n * VOTES);
      chk("en_cycles", en_cyc, n * VOTES * SC);
      chk("en_onehot", bad_en, 0);
    end else begin
      chk("en_cycles", en_cyc, 0);
    end
    for (int k = 0; k < n; k++) begin
      idx = busy_cyc - 1 - n + k;
      chk($sformatf("so[%0d]", k), (idx >= 0 && idx < so_hist.size()) ? so_hist[idx] : 1'bx,
          exp_so_q.pop_front());
    end
    for (int i = 0; i < so_hist.size(); i++) begin
      if ((i < busy_cyc - 1 - n || i > busy_cyc - 2) && so_hist[i] !== 1'b0) so_stray++;
    end
    chk("so_outside_unload", so_stray, 0);
    chk("sel_err", sel_err, !valid);
    exp_chal_q.delete();
    chal_model = cm;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    si         = 1'b0;
    scan_en    = 1'b0;
    start      = 1'b0;
    puf_sel    = 2'd0;
    length     = 2'd0;
    resp_mode  = 1'b0;
    resp_const = 3'b100;
    chal_model = '0;
    do_reset();
    chk("rst_puf_en", puf_en, 3'b000);
    chk("rst_puf_chal", puf_chal, 32'h0);
    chk("rst_so", so, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sel_err", sel_err, 1'b0);

    // scan-in, then start with scan_en also high and a second start while busy
    scan_in(32'hA5A5_0F0F);
    run_op(2'd2, 2'd0, 1'b1, 1'b1);

    // all-zero challenge is forced to 1, then 16 LFSR-stepped bits
    do_reset();
    resp_mode = 1'b1;
    run_op(2'd0, 2'd1, 1'b0, 1'b0);

    // invalid select, then a valid start clears sel_err
    resp_mode = 1'b0;
    run_op(2'd3, 2'd0, 1'b0, 1'b0);
    scan_in(32'h1234_5678);
    resp_mode = 1'b1;
    run_op(2'd1, 2'd3, 1'b0, 1'b0);

    // asynchronous reset in the middle of EVAL
    resp_mode = 1'b0;
    @(negedge clk);
    puf_sel = 2'd0;
    length  = 2'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_en_before", puf_en, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_puf_en", puf_en, 3'b000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_so", so, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_chal", puf_chal, 32'h0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_en", puf_en, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
